// File: rtl/minisys_md_ctrl.sv
// -----------------------------------------------------------------------------
// minisys_md_ctrl
// Iterative multiply/divide unit with architectural HI/LO registers.
// A 32-step radix-2 engine handles mult/multu (shift-add) and div/divu
// (restoring shift-subtract). Signed operations are done on magnitudes and
// sign-corrected in the FIX state, which also writes HI/LO.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   md_startE, md_opE   : issue strobe and op (00 mult, 01 multu, 10 div, 11 divu)
//   srcaE, srcbE        : operand A (multiplicand/dividend), B (multiplier/divisor)
//   mthiE, mtloE        : write srcaE into HI / LO
//   mfhiE, mfloE        : EX-stage read of HI / LO (only affects md_stall)
//   flushE              : abort whatever is in flight, no HI/LO write
//   hi, lo              : architectural HI/LO registers
//   md_busy             : engine not idle
//   md_stall            : combinational stall request to the pipeline
//   md_done             : one-cycle completion pulse (cycle before HI/LO write)
//   mdcs                : one-cycle pulse in the cycle before any HI/LO write
// -----------------------------------------------------------------------------
module minisys_md_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_startE,
  input  logic [1:0]  md_opE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        mthiE,
  input  logic        mtloE,
  input  logic        mfhiE,
  input  logic        mfloE,
  input  logic        flushE,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_busy,
  output logic        md_stall,
  output logic        md_done,
  output logic        mdcs
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;      // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] opnd_q;     // magnitude added (mult) or subtracted (div) each step
  logic        is_div_q;
  logic        neg_lo_q;   // negate product (mult) or quotient (div)
  logic        neg_hi_q;   // negate remainder (div only)
  logic [31:0] hi_q, lo_q;

  // Issue-side decode
  logic        is_signed, is_div, a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag;

  assign is_signed = ~md_opE[0];
  assign is_div    = md_opE[1];
  assign a_neg     = is_signed & srcaE[31];
  assign b_neg     = is_signed & srcbE[31];
  assign a_mag     = a_neg ? (~srcaE + 32'd1) : srcaE;
  assign b_mag     = b_neg ? (~srcbE + 32'd1) : srcbE;
  assign div_zero  = is_div & (srcbE == 32'd0);

  logic issue, mt_write, fix_write;
  assign issue     = (state_q == S_IDLE) & md_startE & ~flushE;
  assign mt_write  = (state_q == S_IDLE) & ~md_startE & ~flushE & (mthiE | mtloE);
  assign fix_write = (state_q == S_FIX) & ~flushE;

  // One iteration step of either engine
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic [63:0] mul_next, div_next;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    // Shift next dividend bit into the remainder and try to subtract.
    rem_sh   = {acc_q[63:32], acc_q[31]};
    diff     = {1'b0, rem_sh} - {2'b00, opnd_q};
    div_next = diff[33] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                        : {diff[31:0],   acc_q[30:0], 1'b1};
  end

  // Sign correction applied in FIX
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  assign prod_fix = neg_lo_q ? (~acc_q + 64'd1) : acc_q;
  assign quo_fix  = neg_lo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix  = neg_hi_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (issue) state_d = div_zero ? S_FIX : S_CALC;
      S_CALC: begin
        if (flushE)                state_d = S_IDLE;
        else if (cnt_q == 6'd31)   state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the datapath registers are cleared on reset as well, so an aborted
  // operation leaves no stale operands behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (issue) begin
      cnt_q    <= 6'd0;
      is_div_q <= is_div;
      if (div_zero) begin
        // Result is fixed: HI = dividend as given, LO = all ones.
        acc_q    <= {srcaE, 32'hFFFF_FFFF};
        opnd_q   <= 32'd0;
        neg_lo_q <= 1'b0;
        neg_hi_q <= 1'b0;
      end else begin
        acc_q    <= {32'd0, is_div ? a_mag : b_mag};
        opnd_q   <= is_div ? b_mag : a_mag;
        neg_lo_q <= a_neg ^ b_neg;
        neg_hi_q <= is_div & a_neg;
      end
    end else if (state_q == S_CALC && !flushE) begin
      acc_q <= is_div_q ? div_next : mul_next;
      cnt_q <= cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (fix_write) begin
      hi_q <= is_div_q ? rem_fix : prod_fix[63:32];
      lo_q <= is_div_q ? quo_fix : prod_fix[31:0];
    end else if (mt_write) begin
      if (mthiE) hi_q <= srcaE;
      if (mtloE) lo_q <= srcaE;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_busy  = (state_q != S_IDLE);
  assign md_stall = md_busy & (md_startE | mthiE | mtloE | mfhiE | mfloE);
  assign md_done  = fix_write;
  // The idle-state mthi/mtlo path is purely combinational from inputs, so it
  // is gated with rst_n to keep mdcs quiet while reset is held.
  assign mdcs     = (fix_write | mt_write) & rst_n;

endmodule

// File: tb/tb_minisys_md_ctrl.sv
// -----------------------------------------------------------------------------
// tb_minisys_md_ctrl
// Randomised and directed stimulus against a high-level arithmetic model.
// Expected HI/LO updates are queued when stimulus is issued; a monitor pops
// one entry per mdcs pulse and compares HI/LO after the following edge.
// -----------------------------------------------------------------------------
module tb_minisys_md_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        md_startE, mthiE, mtloE, mfhiE, mfloE, flushE;
  logic [1:0]  md_opE;
  logic [31:0] srcaE, srcbE;
  logic [31:0] hi, lo;
  logic        md_busy, md_stall, md_done, mdcs;

  minisys_md_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .md_startE(md_startE), .md_opE(md_opE),
    .srcaE(srcaE), .srcbE(srcbE),
    .mthiE(mthiE), .mtloE(mtloE), .mfhiE(mfhiE), .mfloE(mfloE),
    .flushE(flushE),
    .hi(hi), .lo(lo),
    .md_busy(md_busy), .md_stall(md_stall), .md_done(md_done), .mdcs(mdcs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;   // 1 for a multiply/divide completion, 0 for mthi/mtlo
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: MIPS HI/LO semantics with plain 64-bit arithmetic.
  function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Monitor: one queue entry per mdcs pulse, HI/LO compared after the edge.
  logic pend = 1'b0;
  exp_t pend_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("hilo_update", {hi, lo}, {pend_e.hi, pend_e.lo});
        pend = 1'b0;
      end
      if (mdcs) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mdcs actual=1 expected=0 at %0t", $time);
        end else begin
          pend_e = sb_q.pop_front();
          check("done_with_mdcs", {63'd0, md_done}, {63'd0, pend_e.done});
          pend = 1'b1;
        end
      end
    end
  end

  // Drives one issue cycle; returns on the negedge after the issue edge.
  task automatic start_raw(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic mth, input logic mtl);
    @(negedge clk);
    md_opE = op; srcaE = a; srcbE = b;
    md_startE = 1'b1; mthiE = mth; mtloE = mtl;
    @(negedge clk);
    md_startE = 1'b0; mthiE = 1'b0; mtloE = 1'b0;
  endtask

  task automatic issue_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic mth, input logic mtl);
    logic [63:0] r;
    exp_t        e;
    int          busy_n, done_n, done_at, lat;
    bit          finished;
    r = ref_md(op, a, b);
    e.hi = r[63:32]; e.lo = r[31:0]; e.done = 1'b1;
    sb_q.push_back(e);
    m_hi = r[63:32]; m_lo = r[31:0];
    lat = (op[1] && b == 32'd0) ? 1 : 33;
    busy_n = 0; done_n = 0; done_at = 0; finished = 1'b0;
    start_raw(op, a, b, mth, mtl);
    for (int i = 1; i <= 60; i++) begin
      if (!md_busy) begin
        finished = 1'b1;
        break;
      end
      busy_n++;
      if (md_done) begin
        done_n++;
        done_at = i;
      end
      @(negedge clk);
    end
    check("op_timeout", {63'd0, finished}, 64'd1);
    check("busy_cycles", 64'(busy_n), 64'(lat));
    check("done_pulses", 64'(done_n), 64'd1);
    check("done_latency", 64'(done_at), 64'(lat));
  endtask

  task automatic mt_write(input logic mth, input logic mtl, input logic [31:0] a);
    exp_t e;
    e.hi = mth ? a : m_hi;
    e.lo = mtl ? a : m_lo;
    e.done = 1'b0;
    sb_q.push_back(e);
    m_hi = e.hi; m_lo = e.lo;
    @(negedge clk);
    srcaE = a; mthiE = mth; mtloE = mtl;
    @(negedge clk);
    mthiE = 1'b0; mtloE = 1'b0;
  endtask

  initial begin
    logic [63:0] r;
    exp_t        e;
    int          stall_bad;
    logic [1:0]  op;
    logic [31:0] a, b;

    rst_n = 1'b0;
    md_startE = 1'b0; md_opE = 2'b00; srcaE = 32'd0; srcbE = 32'd0;
    mthiE = 1'b1; mtloE = 1'b0; mfhiE = 1'b0; mfloE = 1'b0; flushE = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {hi, lo}, 64'd0);
    check("reset_flags", {60'd0, md_busy, md_stall, md_done, mdcs}, 64'd0);
    mthiE = 1'b0;
    rst_n = 1'b1;

    // Directed results
    issue_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    check("mult_m3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    issue_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    check("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    issue_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("div_min_m1", {hi, lo}, {32'd0, 32'h8000_0000});
    issue_op(2'b10, 32'd5, 32'd0, 1'b0, 1'b0);
    check("div_by_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});

    // mthi/mtlo in idle, singly and together; mfhi alone changes nothing
    mt_write(1'b0, 1'b1, 32'h1234_5678);
    mt_write(1'b1, 1'b0, 32'hCAFE_F00D);
    mt_write(1'b1, 1'b1, 32'h0BAD_BEEF);
    @(negedge clk);
    mfhiE = 1'b1;
    #1;
    check("mfhi_idle", {62'd0, md_stall, mdcs}, 64'd0);
    @(negedge clk);
    mfhiE = 1'b0;
    check("mfhi_no_change", {hi, lo}, {m_hi, m_lo});

    // Start with mthi/mtlo in the same cycle: only the start takes effect
    issue_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);

    // mflo issued mid-multu stalls until idle, then reads the new LO
    r = ref_md(2'b01, 32'hDEAD_BEEF, 32'h0001_0003);
    e.hi = r[63:32]; e.lo = r[31:0]; e.done = 1'b1;
    sb_q.push_back(e);
    m_hi = r[63:32]; m_lo = r[31:0];
    start_raw(2'b01, 32'hDEAD_BEEF, 32'h0001_0003, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    mfloE = 1'b1;
    #1;
    stall_bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (!md_busy) break;
      if (!md_stall) stall_bad++;
      @(negedge clk);
    end
    #1;
    check("mflo_stall_while_busy", 64'(stall_bad), 64'd0);
    check("mflo_busy_ends", {63'd0, md_busy}, 64'd0);
    check("mflo_stall_released", {63'd0, md_stall}, 64'd0);
    check("mflo_sees_new_lo", {32'd0, lo}, {32'd0, r[31:0]});
    mfloE = 1'b0;

    // Flush mid-divide: back to idle, HI/LO unchanged, no done
    start_raw(2'b10, 32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    flushE = 1'b1;
    #1;
    check("flush_busy_before", {62'd0, md_busy, md_done}, 64'd2);
    @(negedge clk);
    flushE = 1'b0;
    check("flush_idle", {63'd0, md_busy}, 64'd0);
    check("flush_hilo_kept", {hi, lo}, {m_hi, m_lo});

    // Flush in the same cycle as start and mthi: nothing happens
    @(negedge clk);
    md_startE = 1'b1; mthiE = 1'b1; flushE = 1'b1; srcaE = 32'h5555_AAAA;
    md_opE = 2'b00; srcbE = 32'd9;
    @(negedge clk);
    md_startE = 1'b0; mthiE = 1'b0; flushE = 1'b0;
    check("flush_overrides_start", {63'd0, md_busy}, 64'd0);
    check("flush_overrides_mthi", {hi, lo}, {m_hi, m_lo});

    // Flush while in FIX (divide by zero): no write, no pulses
    start_raw(2'b11, 32'd77, 32'd0, 1'b0, 1'b0);
    flushE = 1'b1;
    #1;
    check("flush_fix_quiet", {61'd0, md_busy, md_done, mdcs}, 64'd4);
    @(negedge clk);
    flushE = 1'b0;
    check("flush_fix_hilo", {hi, lo}, {m_hi, m_lo});

    // Reset mid-multiply, then a normal multiply
    start_raw(2'b00, 32'h7FFF_0001, 32'h0000_FFFF, 1'b0, 1'b0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_hilo", {hi, lo}, 64'd0);
    check("midreset_flags", {61'd0, md_busy, md_done, mdcs}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    issue_op(2'b00, 32'h7FFF_0001, 32'h0000_FFFF, 1'b0, 1'b0);

    // Randomised mix of ops, corner operands and idle writes
    for (int n = 0; n < 30; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0)
        mt_write(1'($urandom_range(0, 1)), 1'b1, $urandom);
      issue_op(op, a, b, 1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
